// File: rtl/serializer.sv
// Serial link transmitter: shifts a parallel word out MSB first, one bit per
// clock, with a per-bit valid strobe and back-to-back word acceptance.
module serializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  localparam int RW = MOD_W + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [RW-1:0]     rem_q;
  logic              ser_data_q;
  logic              ser_val_q;
  logic              busy_q;

  logic              mod_ok;
  logic              accept;
  logic [RW-1:0]     len;

  assign mod_ok = (data_mod_i == '0) ||
                  (data_mod_i >= MOD_W'(3));
  assign accept = data_val_i & ~busy_q & mod_ok;
  assign len    = (data_mod_i == '0) ? RW'(DATA_W)
                                     : {1'b0, data_mod_i};

  // busy_q is low only in IDLE or on the last bit, so accept covers both
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rem_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else if (accept) begin
      state_q    <= SEND;
      shift_q    <= data_i << 1;
      rem_q      <= len - 1'b1;
      ser_data_q <= data_i[DATA_W-1];
      ser_val_q  <= 1'b1;
      busy_q     <= 1'b1;
    end else if (state_q == SEND &&
                 rem_q != '0) begin
      shift_q    <= shift_q << 1;
      rem_q      <= rem_q - 1'b1;
      ser_data_q <= shift_q[DATA_W-1];
      ser_val_q  <= 1'b1;
      busy_q     <= (rem_q != RW'(1));
    end else begin
      state_q    <= IDLE;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end
  end

  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: directed scenarios plus random words checked
// cycle by cycle against a queue of expected serial bits.
module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  serializer dut (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .data_i        (data_i),
    .data_mod_i    (data_mod_i),
    .data_val_i    (data_val_i),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int   tests = 0;
  int   fails = 0;
  bit   q[$];
  logic [31:0] got;
  int   gotn;
  int   busyn;
  int   total_exp;
  int   total_got;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, check outputs mid-cycle
  task automatic cyc(input logic val,
                     input logic [15:0] d,
                     input logic [3:0] m,
                     input logic rst,
                     output bit acc);
    bit busy_m;
    bit ok;
    int len;
    srst_i     = rst;
    data_val_i = val;
    data_i     = d;
    data_mod_i = m;
    busy_m = q.size() > 1;
    ok     = (m == 0) || (m >= 3);
    acc    = 1'b0;
    @(posedge clk_i);
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (val && !busy_m && ok) begin
        acc = 1'b1;
        len = (m == 0) ? 16 : int'(m);
        total_exp += len;
        for (int i = 0; i < len; i++)
          q.push_back(d[15-i]);
      end
    end
    @(negedge clk_i);
    chk("ser_val", 32'(ser_data_val_o),
        32'(q.size() > 0));
    chk("ser_data", 32'(ser_data_o),
        32'((q.size() > 0) ? q[0] : 1'b0));
    chk("busy", 32'(busy_o), 32'(q.size() > 1));
    if (ser_data_val_o === 1'b1) begin
      got = {got[30:0], ser_data_o};
      gotn++;
      total_got++;
    end
    if (busy_o === 1'b1) busyn++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++)
      cyc(1'b0, 16'h0, 4'h0, 1'b0, a);
  endtask

  task automatic clr();
    got = '0;
    gotn = 0;
    busyn = 0;
  endtask

  initial begin
    bit a;
    int gap;
    int r;
    logic [3:0] m;
    total_exp = 0;
    total_got = 0;
    clr();
    cyc(1'b0, 16'h0, 4'h0, 1'b1, a);
    cyc(1'b1, 16'hFFFF, 4'h0, 1'b1, a);
    chk("reset_val", 32'(ser_data_val_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);

    // full-width word
    clr();
    cyc(1'b1, 16'hA5C3, 4'h0, 1'b0, a);
    idle(18);
    chk("t1_count", 32'(gotn), 32'd16);
    chk("t1_bits", got, 32'h0000A5C3);
    chk("t1_busy", 32'(busyn), 32'd15);

    // minimum length word
    clr();
    cyc(1'b1, 16'hE5FF, 4'd3, 1'b0, a);
    idle(4);
    chk("t2_count", 32'(gotn), 32'd3);
    chk("t2_bits", got, 32'h7);
    chk("t2_busy", 32'(busyn), 32'd2);

    // invalid lengths ignored
    clr();
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 16'hFFFF, 4'd1, 1'b0, a);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 16'hFFFF, 4'd2, 1'b0, a);
    chk("t3_count", 32'(gotn), 32'd0);
    chk("t3_busy", 32'(busyn), 32'd0);

    // held request during busy, gapless follow-on
    clr();
    cyc(1'b1, 16'h8001, 4'h0, 1'b0, a);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 16'hFFFF, 4'h0, 1'b0, a);
    chk("t4_accept_last", 32'(a), 32'd1);
    idle(20);
    chk("t4_count", 32'(gotn), 32'd32);
    chk("t4_bits", got, 32'h8001FFFF);

    // reset mid-word
    clr();
    cyc(1'b1, 16'h9C3B, 4'h0, 1'b0, a);
    idle(4);
    chk("t5_partial", 32'(gotn), 32'd5);
    cyc(1'b0, 16'h0, 4'h0, 1'b1, a);
    chk("t5_rst_val", 32'(ser_data_val_o), 32'd0);
    chk("t5_rst_dat", 32'(ser_data_o), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    clr();
    cyc(1'b1, 16'h1234, 4'h0, 1'b0, a);
    idle(18);
    chk("t5_count", 32'(gotn), 32'd16);
    chk("t5_bits", got, 32'h00001234);

    // random words
    total_exp = 0;
    total_got = 0;
    for (int w = 0; w < 1000; w++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        r = $urandom_range(0, 3);
        if (r == 0)
          cyc(1'b1, 16'($urandom), 4'($urandom_range(1, 2)),
              1'b0, a);
        else
          cyc(1'b0, 16'($urandom), 4'($urandom), 1'b0, a);
      end
      a = 1'b0;
      for (int k = 0; k < 40 && !a; k++) begin
        r = $urandom_range(0, 13);
        m = (r == 0) ? 4'd0 : 4'(r + 2);
        cyc(1'b1, 16'($urandom), m, 1'b0, a);
      end
      chk("t6_accept", 32'(a), 32'd1);
    end
    idle(20);
    chk("t6_total", 32'(total_got), 32'(total_exp));
    chk("t6_idle", 32'(ser_data_val_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
